// File: rtl/wave_generator_param.sv
// Purpose: multi-mode periodic waveform generator (triangle, saw up, saw down, square).
// Latency: wave/cycle_start change on the same edge that advances phase; no extra stage.
// Backpressure: none; free-running whenever en is high, en low holds it at the start value.
module wave_generator_param #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  max_val,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  wave,
    output logic              cycle_start,
    output logic [1:0]        mode_active
);

    typedef enum logic [1:0] {
        MODE_TRI    = 2'd0,
        MODE_SAW_UP = 2'd1,
        MODE_SAW_DN = 2'd2,
        MODE_SQUARE = 2'd3
    } mode_e;

    // One guard bit so that phase + step never wraps before the compare.
    localparam int XW = WIDTH + 1;

    // Applied (shadow) configuration; only reloaded while idle or at a boundary.
    mode_e             cfg_mode_q, cfg_mode_d;
    logic [WIDTH-1:0]  cfg_max_q,  cfg_max_d;
    logic [STEP_W-1:0] cfg_step_q, cfg_step_d;

    // Waveform state.
    logic [WIDTH-1:0]  phase_q, phase_d;
    logic              dir_q,   dir_d;
    logic              cs_q,    cs_d;
    logic [WIDTH-1:0]  wave_q,  wave_d;

    // Arithmetic helpers.
    logic [XW-1:0]     st_x;
    logic [XW-1:0]     phase_x;
    logic [XW-1:0]     max_x;
    logic [XW-1:0]     sum_x;
    logic [WIDTH-1:0]  st_w;
    logic [WIDTH-1:0]  diff_w;
    logic [WIDTH-1:0]  start_val;
    logic              boundary;
    logic              load_cfg;

    // Effective step (zero means one) and the widened operands used for all compares.
    always_comb begin
        st_x = {{(XW-STEP_W){1'b0}}, cfg_step_q};
        if (cfg_step_q == '0) begin
            st_x = XW'(1);
        end
        phase_x   = {1'b0, phase_q};
        max_x     = {1'b0, cfg_max_q};
        sum_x     = phase_x + st_x;
        st_w      = st_x[WIDTH-1:0];
        diff_w    = phase_q - st_w;
        // Start value follows the live inputs: it is only used when they are being loaded.
        start_val = (mode == 2'd2) ? max_val : '0;
    end

    // Per-mode phase advance; flags the edge that closes a waveform period.
    always_comb begin
        phase_d  = phase_q;
        dir_d    = dir_q;
        boundary = 1'b0;
        if (en) begin
            case (cfg_mode_q)
                MODE_TRI, MODE_SQUARE: begin
                    if (dir_q) begin
                        if (sum_x >= max_x) begin
                            phase_d = cfg_max_q;
                            dir_d   = 1'b0;
                        end else begin
                            phase_d = sum_x[WIDTH-1:0];
                        end
                    end else begin
                        if (phase_x <= st_x) begin
                            boundary = 1'b1;
                        end else begin
                            phase_d = diff_w;
                        end
                    end
                end
                MODE_SAW_UP: begin
                    if (phase_q == cfg_max_q) begin
                        boundary = 1'b1;
                    end else if (sum_x >= max_x) begin
                        phase_d = cfg_max_q;
                    end else begin
                        phase_d = sum_x[WIDTH-1:0];
                    end
                end
                MODE_SAW_DN: begin
                    if (phase_q == '0) begin
                        boundary = 1'b1;
                    end else if (phase_x <= st_x) begin
                        phase_d = '0;
                    end else begin
                        phase_d = diff_w;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Config reload and restart: while idle every cycle, while running only at a boundary.
    always_comb begin
        load_cfg   = !en || boundary;
        cfg_mode_d = cfg_mode_q;
        cfg_max_d  = cfg_max_q;
        cfg_step_d = cfg_step_q;
        cs_d       = boundary;
        if (load_cfg) begin
            cfg_mode_d = mode_e'(mode);
            cfg_max_d  = max_val;
            cfg_step_d = step;
        end
    end

    // Output sample computed from next state so wave leaves the block straight from a flop.
    always_comb begin
        if (load_cfg) begin
            wave_d = (mode_e'(mode) == MODE_SQUARE) ? max_val : start_val;
        end else if (cfg_mode_q == MODE_SQUARE) begin
            wave_d = dir_d ? cfg_max_q : '0;
        end else begin
            wave_d = phase_d;
        end
    end

    // State register; reset brings up a full-scale unit-step triangle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mode_q <= MODE_TRI;
            cfg_max_q  <= '1;
            cfg_step_q <= STEP_W'(1);
            phase_q    <= '0;
            dir_q      <= 1'b1;
            cs_q       <= 1'b0;
            wave_q     <= '0;
        end else begin
            cfg_mode_q <= cfg_mode_d;
            cfg_max_q  <= cfg_max_d;
            cfg_step_q <= cfg_step_d;
            cs_q       <= cs_d;
            wave_q     <= wave_d;
            if (load_cfg) begin
                phase_q <= start_val;
                dir_q   <= 1'b1;
            end else begin
                phase_q <= phase_d;
                dir_q   <= dir_d;
            end
        end
    end

    assign wave        = wave_q;
    assign cycle_start = cs_q;
    assign mode_active = cfg_mode_q;

endmodule

// File: tb/tb_wave_generator_param.sv
// Purpose: directed scoreboard bench for wave_generator_param (WIDTH 8, STEP_W 4).
// Latency: each pushed entry is the expected output one edge after its inputs are applied.
// Backpressure: none; the bench consumes one scoreboard entry per clock edge.
module tb_wave_generator_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] max_val;
    logic [3:0] step;
    logic [7:0] wave;
    logic       cycle_start;
    logic [1:0] mode_active;

    typedef struct packed {
        logic [7:0] w;
        logic       cs;
        logic [1:0] ma;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;

    wave_generator_param #(.WIDTH(8), .STEP_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .max_val     (max_val),
        .step        (step),
        .wave        (wave),
        .cycle_start (cycle_start),
        .mode_active (mode_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic push(input int w, input bit cs, input int ma);
        exp_t e;
        e.w  = 8'(w);
        e.cs = cs;
        e.ma = 2'(ma);
        sb_q.push_back(e);
    endtask

    // Advance one edge per entry and compare outputs against the scoreboard.
    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb_q.size() == 0) begin
                checks++;
                $error("FAIL sb_empty@%0d: observed 0 entries expected 1", cyc);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("wave@%0d", cyc), wave, e.w);
                chk($sformatf("cycle_start@%0d", cyc), cycle_start, e.cs);
                chk($sformatf("mode_active@%0d", cyc), mode_active, e.ma);
            end
        end
    endtask

    task automatic idle(input int m, input int mx, input int st, input int exp_w);
        en      = 1'b0;
        mode    = 2'(m);
        max_val = 8'(mx);
        step    = 4'(st);
        push(exp_w, 0, m);
        run(1);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; max_val = 8'd0; step = 4'd0;
        #1;
        chk("reset_wave", wave, 0);
        chk("reset_cs", cycle_start, 0);
        chk("reset_mode", mode_active, 0);
        #2 rst_n = 1'b1;

        // Triangle M=31, step 1: two cycles idle then two full periods.
        en = 1'b0; mode = 2'd0; max_val = 8'd31; step = 4'd1;
        push(0, 0, 0); push(0, 0, 0);
        run(2);
        en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int v = 1; v <= 31; v++) push(v, 0, 0);
            for (int v = 30; v >= 1; v--) push(v, 0, 0);
            push(0, 1, 0);
        end
        run(sb_q.size());

        // Non-divisible steps, max 10.
        idle(0, 10, 4, 0);
        en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            push(4, 0, 0); push(8, 0, 0); push(10, 0, 0); push(6, 0, 0); push(2, 0, 0);
            push(0, 1, 0);
        end
        run(sb_q.size());

        idle(1, 10, 3, 0);
        en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            push(3, 0, 1); push(6, 0, 1); push(9, 0, 1); push(10, 0, 1);
            push(0, 1, 1);
        end
        run(sb_q.size());

        idle(2, 10, 4, 10);
        en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            push(6, 0, 2); push(2, 0, 2); push(0, 0, 2);
            push(10, 1, 2);
        end
        run(sb_q.size());

        // Square, max 31, step 1: 31 high, 31 low.
        idle(3, 31, 1, 31);
        en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int v = 0; v < 30; v++) push(31, 0, 3);
            for (int v = 0; v < 31; v++) push(0, 0, 3);
            push(31, 1, 3);
        end
        run(sb_q.size());

        // Deferred configuration change at wave 15 going up.
        idle(0, 31, 1, 0);
        en = 1'b1;
        for (int v = 1; v <= 15; v++) push(v, 0, 0);
        run(sb_q.size());
        mode = 2'd1; max_val = 8'd7;
        for (int v = 16; v <= 31; v++) push(v, 0, 0);
        for (int v = 30; v >= 1; v--) push(v, 0, 0);
        push(0, 1, 1);
        for (int v = 1; v <= 7; v++) push(v, 0, 1);
        push(0, 1, 1);
        run(sb_q.size());

        // Step 0 behaves as step 1.
        idle(0, 10, 0, 0);
        en = 1'b1;
        for (int v = 1; v <= 10; v++) push(v, 0, 0);
        for (int v = 9; v >= 1; v--) push(v, 0, 0);
        push(0, 1, 0);
        run(sb_q.size());

        // max 0: saw fires every cycle, triangle every second cycle.
        idle(1, 0, 1, 0);
        en = 1'b1;
        for (int v = 0; v < 5; v++) push(0, 1, 1);
        run(sb_q.size());
        idle(0, 0, 1, 0);
        en = 1'b1;
        for (int v = 0; v < 3; v++) begin
            push(0, 0, 0); push(0, 1, 0);
        end
        run(sb_q.size());

        // Async reset mid-operation at wave 20, then default full-scale triangle.
        idle(0, 31, 1, 0);
        en = 1'b1;
        for (int v = 1; v <= 20; v++) push(v, 0, 0);
        run(sb_q.size());
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_wave", wave, 0);
        chk("async_reset_cs", cycle_start, 0);
        chk("async_reset_mode", mode_active, 0);
        @(posedge clk);
        #1;
        chk("held_reset_wave", wave, 0);
        #1 rst_n = 1'b1;
        for (int v = 1; v <= 40; v++) push(v, 0, 0);
        run(sb_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/wave_generator_param.md
# wave_generator_param

Parametrised multi-mode periodic waveform generator for the signal-generation datapath. Produces triangle, sawtooth-up, sawtooth-down or square waves of programmable amplitude and step on a WIDTH-bit output. Configuration is double-buffered and only takes effect at a waveform-cycle boundary, so mode or amplitude changes never produce glitches. A one-cycle `cycle_start` pulse is provided for downstream synchronisation.

## Interface
- `WIDTH`, default 8: wave/amplitude width.
- `STEP_W`, default 4: step input width; must satisfy STEP_W <= WIDTH.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `en`  input  1: 1 = run; 0 = idle/restart.
- `mode`  input  2: 0 triangle, 1 saw up, 2 saw down, 3 square.
- `max_val`  input  WIDTH: peak value.
- `step`  input  STEP_W: increment per cycle; 0 is treated as 1.
- `wave`  output  WIDTH: waveform sample, driven from registers only.
- `cycle_start`  output  1: registered pulse, high in the first cycle of each waveform period.
- `mode_active`  output  2: currently applied mode (`cfg_mode`).

## Operation
- State:
  - `phase` [WIDTH-1:0], `dir` (1 = up).
  - Config shadows `cfg_mode`, `cfg_max`, `cfg_step`.
  - `cycle_start` register.
- `st` = `cfg_step`, or 1 if `cfg_step` == 0. Zero-extend to WIDTH+1 bits. All sums and compares use WIDTH+1 bits, so nothing wraps.
- Start value:
  - `max_val` if `mode` == 2.
  - 0 otherwise.
- `en` = 0, every cycle:
  - cfg_* load from the inputs.
  - `phase` loads the start value of the input mode.
  - `dir` = 1 and `cycle_start` = 0.
- `en` = 1, triangle or square (modes 0/3):
  - `dir` = 1: if `phase` + `st` >= `cfg_max`, then `phase` = `cfg_max` and `dir` = 0. Otherwise `phase` += `st`.
  - `dir` = 0: if `phase` <= `st`, this is a boundary. Otherwise `phase` -= `st`.
- `en` = 1, saw up (mode 1):
  - `phase` == `cfg_max`: boundary.
  - Otherwise `phase` = min(`phase` + `st`, `cfg_max`).
- `en` = 1, saw down (mode 2):
  - `phase` == 0: boundary.
  - `phase` <= `st`: `phase` = 0.
  - Otherwise `phase` -= `st`.
- Boundary edge:
  - cfg_* load from the inputs.
  - `phase` loads the start value of the new mode, using the new `max_val` for mode 2.
  - `dir` = 1 and `cycle_start` = 1.
  - On every non-boundary edge, `cycle_start` = 0.
- Output mapping:
  - Modes 0/1/2: `wave` = `phase`.
  - Mode 3: `wave` = `dir` ? `cfg_max` : 0. `phase` still runs the triangle internally.
- Input changes while `en` = 1 are ignored until the next boundary edge.
- `cfg_max` = 0:
  - Triangle/square: `wave` is constant 0 and `cycle_start` fires every 2 cycles.
  - Saws: `cycle_start` fires every cycle.
- `dir` stays 1 in saw modes.

## Timing
- Reset (async assert; release is synchronised externally):
  - `phase` = 0, `dir` = 1, `cycle_start` = 0.
  - `cfg_mode` = 0, `cfg_max` = all ones, `cfg_step` = 1.
  - Resulting outputs: `wave` = 0, `mode_active` = 0.
- First edge after reset with `en` = 1 runs the default triangle: `wave` = 1.
- Latency:
  - `wave` changes on the edge that updates `phase`/`dir`; there is no extra pipeline stage.
  - `cycle_start` is high in the same cycle `wave` shows the start value.
- `en` 1 -> 0: on the next edge, `wave` shows the start value of the current `mode` input.
- `en` 0 -> 1: the first enabled edge advances from the start value. No `cycle_start` is produced for this restart.
- Periods when `st` divides `cfg_max` (M = `cfg_max`):
  - Triangle/square: 2·M/`st`.
  - Saws: M/`st` + 1.
- Square duty: high during the up half (`phase` 0..M-`st`), low from the peak until the boundary.
- Async reset mid-cycle: immediate return to reset values, with no partial-cycle completion.

## Test plan
- Triangle, M=31, `st`=1:
  - Stimulus: `en` low 2 cycles (mode 0, `max_val` 31, `step` 1), then `en` high.
  - Required `wave`: 0, 1..31, 30..1, 0, 1...
  - `cycle_start` high with every `wave` = 0 after the first; period 62.
- Non-divisible steps, `max_val` 10, `step` 4:
  - Mode 0: `wave` = 0, 4, 8, 10, 6, 2, 0, repeating.
  - Mode 1 with `step` 3: 0, 3, 6, 9, 10, 0.
  - Mode 2 with `step` 4: 10, 6, 2, 0, 10.
- Square, `max_val` 31, `step` 1:
  - `wave` = 31 for 31 cycles, then 0 for 31 cycles, repeating.
  - `cycle_start` at each rising transition.
- Deferred configuration change:
  - Stimulus: in triangle at `wave` = 15 going up, set `mode` = 1 and `max_val` = 7.
  - Triangle continues to 31 and back to 0.
  - Then saw 0..7 with `cycle_start` at that 0; `mode_active` changes only at that edge.
- Edge cases:
  - `step` 0 behaves exactly as `step` 1.
  - `max_val` 0 in mode 1: `wave` = 0 and `cycle_start` high every cycle.
- Async reset mid-operation:
  - Assert `rst_n` low at `wave` = 20.
  - Outputs go to 0 immediately, without waiting for an edge.
  - After release with `en` high: default triangle with `cfg_max` 255, `wave` = 1, 2, 3...
